game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: top-level game state machine.
// Sequences IDLE/PLAY/PAUSE/END, generates the game tick, keeps score,
// health and high score, applies post-damage invulnerability and issues
// per-enemy respawn commands.
module game_ctrl #(
    parameter int NUM_EN       = 3,
    parameter int HEALTH_MAX   = 3,
    parameter int SCORE_W      = 16,
    parameter int TICK_DIV     = 833333,
    parameter int INVULN_TICKS = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic [NUM_EN-1:0]  hit_en,
    input  logic [NUM_EN-1:0]  reach_en,
    output logic [1:0]         state,
    output logic               game_tick,
    output logic [NUM_EN-1:0]  respawn_en,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [3:0]         health,
    output logic               game_end
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int INV_W  = $clog2(INVULN_TICKS + 2);
    localparam int CNT_W  = $clog2(NUM_EN + 1);
    localparam int SUM_W  = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SUM_W-1:0]  SCORE_MAX = (SUM_W'(1) << SCORE_W) - SUM_W'(1);
    localparam logic [INV_W-1:0]  INV_LOAD  = INV_W'(INVULN_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_END   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [INV_W-1:0]    inv_q, inv_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W-1:0]  high_q, high_d;
    logic [3:0]          health_q, health_d;
    logic [NUM_EN-1:0]   resp_q, resp_d;
    logic                game_tick_q, game_tick_d;
    logic                game_end_q, game_end_d;

    logic [CNT_W-1:0]    hits;
    logic [SUM_W-1:0]    sum;
    logic                tick_now;

    // Next-state logic: FSM transitions plus all per-cycle game bookkeeping.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        inv_d    = inv_q;
        score_d  = score_q;
        high_d   = high_q;
        health_d = health_q;
        resp_d   = '0;

        hits = '0;
        for (int i = 0; i < NUM_EN; i++) begin
            hits = hits + CNT_W'(hit_en[i]);
        end
        sum      = SUM_W'(score_q) + SUM_W'(hits);
        tick_now = (state_q == ST_PLAY) && (tick_q == TICK_LAST);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_PLAY;
                    score_d  = '0;
                    health_d = 4'(HEALTH_MAX);
                    tick_d   = '0;
                    inv_d    = '0;
                end
            end
            ST_PLAY: begin
                if (health_q == 4'd0) begin
                    state_d = ST_END;
                end else if (!start) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end

                tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
                score_d = (sum > SCORE_MAX) ? '1 : sum[SCORE_W-1:0];

                // Damage reload takes priority over the tick-driven countdown.
                if ((|reach_en) && (inv_q == '0)) begin
                    if (health_q != 4'd0) begin
                        health_d = health_q - 4'd1;
                    end
                    inv_d = INV_LOAD;
                end else if (tick_now && (inv_q != '0)) begin
                    inv_d = inv_q - INV_W'(1);
                end

                // Every touched enemy respawns, even when damage was ignored.
                resp_d = hit_en | reach_en;
            end
            ST_PAUSE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_PLAY;
                end
            end
            ST_END: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if ((state_d == ST_END) && (state_q != ST_END) && (score_d > high_q)) begin
            high_d = score_d;
        end

        game_tick_d = (state_d == ST_PLAY) && (tick_d == TICK_LAST);
        game_end_d  = (state_d == ST_END);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            inv_q       <= '0;
            score_q     <= '0;
            high_q      <= '0;
            health_q    <= '0;
            resp_q      <= '0;
            game_tick_q <= 1'b0;
            game_end_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            inv_q       <= inv_d;
            score_q     <= score_d;
            high_q      <= high_d;
            health_q    <= health_d;
            resp_q      <= resp_d;
            game_tick_q <= game_tick_d;
            game_end_q  <= game_end_d;
        end
    end

    assign state      = state_q;
    assign game_tick  = game_tick_q;
    assign respawn_en = resp_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign health     = health_q;
    assign game_end   = game_end_q;

endmodule
